// File: rtl/padded_pixel_feeder.sv
// padded_pixel_feeder
//   Streams one zero-padded IMG x IMG feature map, as a (IMG+2) x (IMG+2)
//   raster, into a downstream 3x3 window line buffer. Interior pixels are
//   fetched from a memory with 1-cycle read latency. Border pixels are
//   synthesized as zeros. One padded position is issued per cycle, with no
//   stalls.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle frame request (ignored while busy)
//   busy       frame in progress
//   done       one-cycle pulse in the cycle of the last win_valid
//   rd_en      memory read strobe (interior positions only)
//   rd_addr    row-major read address (holds on border positions)
//   rd_data    memory data, valid 1 cycle after rd_en
//   D          padded pixel stream
//   d_valid    D carries a frame pixel
//   win_valid  line buffer window outputs hold a legal 3x3 window
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing padded positions (0,0)..(P-1,P-1), one per cycle
// FLUSH  | draining the data/window pipeline; done on the last cycle
module padded_pixel_feeder #(
  parameter int DW  = 9,
  parameter int IMG = 224,
  parameter int AW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] D,
  output logic          d_valid,
  output logic          win_valid
);

  localparam int P  = IMG + 2;
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] LAST = CW'(P - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pr, pc;
  logic [AW-1:0] addr_cnt, addr_last;
  logic [1:0]    flush_cnt;
  logic          dv_q, int_q;
  logic          w1, w2, w3;

  logic issue, interior, last_pos, win_src;

  assign issue    = (state == STREAM);
  assign interior = issue && (pr != '0) && (pr != LAST) && (pc != '0) && (pc != LAST);
  assign last_pos = (pr == LAST) && (pc == LAST);
  // A pixel at (pr>=2, pc>=2) completes a window that lies wholly inside
  // the padded frame, so row-wrap windows are never flagged.
  assign win_src  = issue && (pr >= TWO) && (pc >= TWO);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: if (last_pos) state_nxt = FLUSH;
      FLUSH: begin
        // Three flush cycles cover the data stage plus the two window stages.
        if (flush_cnt == 2'd2) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pr        <= '0;
      pc        <= '0;
      addr_cnt  <= '0;
      addr_last <= '0;
      flush_cnt <= '0;
      dv_q      <= 1'b0;
      int_q     <= 1'b0;
      w1        <= 1'b0;
      w2        <= 1'b0;
      w3        <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && start) begin
        pr       <= '0;
        pc       <= '0;
        addr_cnt <= '0;
      end else if (issue) begin
        if (pc == LAST) begin
          pc <= '0;
          pr <= pr + CW'(1);
        end else begin
          pc <= pc + CW'(1);
        end
      end

      // Running address avoids a (pr-1)*IMG multiplier.
      if (interior) begin
        addr_cnt  <= addr_cnt + AW'(1);
        addr_last <= addr_cnt;
      end

      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;

      dv_q  <= issue;
      int_q <= interior;
      w1    <= win_src;
      w2    <= w1;
      w3    <= w2;
    end
  end

  assign busy      = (state != IDLE);
  assign rd_en     = interior;
  assign rd_addr   = interior ? addr_cnt : addr_last;
  // rd_data is only trusted in the cycle after an interior issue. After a
  // reset int_q is clear, so late read data is discarded.
  assign D         = (dv_q && int_q) ? rd_data : '0;
  assign d_valid   = dv_q;
  assign win_valid = w3;

endmodule

// File: tb/tb_padded_pixel_feeder.sv
module tb_padded_pixel_feeder;

  localparam int DW  = 9;
  localparam int IMG = 4;
  localparam int AW  = 16;
  localparam int P   = IMG + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, d_valid, win_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] D;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] hist [0:2*P+3];

  padded_pixel_feeder #(.DW(DW), .IMG(IMG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .D(D), .d_valid(d_valid), .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  // Memory: word[a] = a+1, 1-cycle latency; garbage when not read.
  always @(posedge clk) rd_data <= rd_en ? DW'(rd_addr + 16'd1) : 9'h1FF;

  // Downstream line buffer model: shift register of captured D values.
  always @(posedge clk) begin
    hist[0] <= D;
    for (int i = 1; i <= 2*P+3; i++) hist[i] <= hist[i-1];
  end

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    #12;
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done); end
    vectors++; if (rd_en !== 1'b0)     begin miscompares++; $display("FAIL reset_rd_en: got %b, expected 0", rd_en); end
    vectors++; if (rd_addr !== '0)     begin miscompares++; $display("FAIL reset_rd_addr: got %0d, expected 0", rd_addr); end
    vectors++; if (D !== '0)           begin miscompares++; $display("FAIL reset_D: got %0d, expected 0", D); end
    vectors++; if (d_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_d_valid: got %b, expected 0", d_valid); end
    vectors++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL reset_win_valid: got %b, expected 0", win_valid); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  // Streams one frame and checks every output cycle by cycle against the
  // padded-raster expectation. Cycle c = issue cycle index (0 = first issue).
  // ign_a/ign_b: cycles in which start is raised and must be ignored.
  // restart: raise start in cycle 39 (the cycle after done).
  // pulse: 0 when start is already high from the previous frame.
  task automatic test_frame(input int ign_a, input int ign_b, input bit restart, input bit pulse);
    int reads, wins, k, r, cc, exp_d, exp_addr, ctr;
    bit exp_en, exp_dv, exp_wv;
    logic [DW-1:0] win9 [0:8];
    int ref9 [0:8];
    ref9 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    reads = 0; wins = 0;
    if (pulse) begin @(posedge clk); #1 start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      // read port
      k = c; r = k / P; cc = k % P;
      exp_en = (c < P*P) && r >= 1 && r <= IMG && cc >= 1 && cc <= IMG;
      vectors++;
      if (rd_en !== exp_en) begin miscompares++; $display("FAIL rd_en: got %b, expected %b (cycle %0d)", rd_en, exp_en, c); end
      if (exp_en) begin
        exp_addr = (r - 1) * IMG + (cc - 1);
        vectors++;
        if (rd_addr !== AW'(exp_addr)) begin miscompares++; $display("FAIL rd_addr: got %0d, expected %0d (cycle %0d)", rd_addr, exp_addr, c); end
        reads++;
      end else if (reads > 0 && c < P*P) begin
        vectors++;
        if (rd_addr !== AW'(reads - 1)) begin miscompares++; $display("FAIL rd_addr_hold: got %0d, expected %0d (cycle %0d)", rd_addr, reads - 1, c); end
      end
      // pixel stream
      k = c - 1; r = (k >= 0) ? k / P : 0; cc = (k >= 0) ? k % P : 0;
      exp_dv = (k >= 0) && (k < P*P);
      exp_d  = (exp_dv && r >= 1 && r <= IMG && cc >= 1 && cc <= IMG) ? (r - 1) * IMG + cc : 0;
      vectors++;
      if (d_valid !== exp_dv) begin miscompares++; $display("FAIL d_valid: got %b, expected %b (cycle %0d)", d_valid, exp_dv, c); end
      vectors++;
      if (D !== DW'(exp_d)) begin miscompares++; $display("FAIL D: got %0d, expected %0d (cycle %0d)", D, exp_d, c); end
      // window valid
      k = c - 3; r = (k >= 0) ? k / P : 0; cc = (k >= 0) ? k % P : 0;
      exp_wv = (k >= 0) && (k < P*P) && r >= 2 && cc >= 2;
      vectors++;
      if (win_valid !== exp_wv) begin miscompares++; $display("FAIL win_valid: got %b, expected %b (cycle %0d)", win_valid, exp_wv, c); end
      if (win_valid === 1'b1) begin
        vectors++;
        if (hist[P+2] !== DW'(wins + 1)) begin miscompares++; $display("FAIL win_center: got %0d, expected %0d (window %0d)", hist[P+2], wins + 1, wins); end
        if (wins + 1 == 6) begin
          win9 = '{hist[2*P+3], hist[2*P+2], hist[2*P+1], hist[P+3], hist[P+2], hist[P+1], hist[3], hist[2], hist[1]};
          for (int i = 0; i < 9; i++) begin
            vectors++;
            if (win9[i] !== DW'(ref9[i])) begin miscompares++; $display("FAIL win6_tap%0d: got %0d, expected %0d", i, win9[i], ref9[i]); end
          end
        end
        wins++;
      end
      vectors++;
      if (done !== (c == P*P + 2)) begin miscompares++; $display("FAIL done: got %b, expected %b (cycle %0d)", done, (c == P*P + 2), c); end
      vectors++;
      if (busy !== (c <= P*P + 2)) begin miscompares++; $display("FAIL busy: got %b, expected %b (cycle %0d)", busy, (c <= P*P + 2), c); end
      start = (c == ign_a || c == ign_b || (restart && c == 39)) ? 1'b1 : 1'b0;
    end
    ctr = reads;
    vectors++; if (ctr != IMG*IMG)  begin miscompares++; $display("FAIL read_count: got %0d, expected %0d", ctr, IMG*IMG); end
    vectors++; if (wins != IMG*IMG) begin miscompares++; $display("FAIL win_count: got %0d, expected %0d", wins, IMG*IMG); end
  endtask

  task automatic test_start_ignore();
    test_frame(10, 38, 1'b1, 1'b1);
    test_frame(-1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_frame(-1, -1, 1'b1, 1'b1);
    test_frame(-1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20; c++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    vectors++; if (done !== 1'b0)      begin miscompares++; $display("FAIL midrst_done: got %b, expected 0", done); end
    vectors++; if (rd_en !== 1'b0)     begin miscompares++; $display("FAIL midrst_rd_en: got %b, expected 0", rd_en); end
    vectors++; if (rd_addr !== '0)     begin miscompares++; $display("FAIL midrst_rd_addr: got %0d, expected 0", rd_addr); end
    vectors++; if (D !== '0)           begin miscompares++; $display("FAIL midrst_D: got %0d, expected 0", D); end
    vectors++; if (d_valid !== 1'b0)   begin miscompares++; $display("FAIL midrst_d_valid: got %b, expected 0", d_valid); end
    vectors++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_win_valid: got %b, expected 0", win_valid); end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got done=%b busy=%b, expected 0 0 (cycle %0d)", done, busy, c); end
    end
    test_frame(-1, -1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frame(-1, -1, 1'b0, 1'b1);
    test_start_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/padded_pixel_feeder.md
PADDED_PIXEL_FEEDER -- requirements
Module: padded_pixel_feeder

Interface
REQ-001 SHALL have parameter DW, default 9, meaning pixel data width in bits.
REQ-002 SHALL have parameter IMG, default 224, meaning the unpadded square feature-map edge; the padded edge P = IMG+2 (226 by default).
REQ-003 SHALL have parameter AW, default 16, meaning memory address width; it must satisfy IMG*IMG <= 2^AW.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to stream one frame.
REQ-007 SHALL have port busy, output, 1 bit: high from frame acceptance until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-009 SHALL have port rd_en, output, 1 bit: feature-map memory read strobe.
REQ-010 SHALL have port rd_addr, output, AW bits: row-major read address.
REQ-011 SHALL have port rd_data, input, DW bits: read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port D, output, DW bits: padded pixel stream into the 3x3 window line buffer.
REQ-013 SHALL have port d_valid, output, 1 bit: high while D carries a frame pixel.
REQ-014 SHALL have port win_valid, output, 1 bit: high in cycles where the line buffer's registered window outputs hold a legal 3x3 window.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, FLUSH: IDLE->STREAM on start; STREAM->FLUSH after the last padded position is issued; FLUSH->IDLE after the last win_valid, with done pulsed in that same cycle.
REQ-016 SHALL ignore start while busy=1; a start in the same cycle as done is also ignored.
REQ-017 SHALL, in STREAM, walk padded position (pr,pc) row-major from (0,0) to (P-1,P-1), one position per cycle with no stalls, because the line buffer shifts every cycle.
REQ-018 SHALL, for interior positions (1<=pr<=IMG and 1<=pc<=IMG), assert rd_en with rd_addr=(pr-1)*IMG+(pc-1); for border positions rd_en=0 and rd_addr holds its last value.
REQ-019 SHALL present position k's pixel on D with d_valid=1 exactly 1 cycle after position k is issued: D=rd_data for interior positions, D=0 for border positions.
REQ-020 SHALL drive D=0 and d_valid=0 in every cycle without a frame pixel, including FLUSH and IDLE.
REQ-021 SHALL assert win_valid exactly 2 cycles after D carries a pixel with pr>=2 and pc>=2, giving IMG*IMG win_valid cycles per frame (50176 by default); no window straddling a row wrap is flagged.
REQ-022 SHALL make busy rise the cycle after start is accepted and fall the cycle after done.
REQ-023 SHALL keep total frame latency fixed: done is asserted P*P+2 cycles after the first issue cycle (51078 by default).

Reset
REQ-024 SHALL, on rst=0, immediately clear busy, done, rd_en, rd_addr, D, d_valid, win_valid, the position counters and the pipeline registers, and force IDLE, including mid-frame.
REQ-025 SHALL discard rd_data returning after a mid-frame reset and require a new start after rst=1.

Verification
REQ-026 SHALL cover IMG=4 frame with memory word[a]=a+1: start -> D sequence of 36 values: 6 zeros (row 0); then for each of rows 1..4: 0, row data, 0 (row 1 is 0,1,2,3,4,0); then 6 zeros (row 5); d_valid high for 36 cycles; 16 win_valid cycles; done at issue cycle 38.
REQ-027 SHALL cover read checking with IMG=4: rd_en is asserted exactly 16 times, rd_addr = 0..15 in order, and rd_en=0 on all 20 border positions.
REQ-028 SHALL cover the line buffer connected downstream with IMG=4 in the same data: the first win_valid window center equals 1 and the last equals 16; the window at center 6 is 1,2,3,5,6,7,9,10,11.
REQ-029 SHALL cover start pulsed during STREAM and start coincident with done -> no restart, exactly one done per frame; a start one cycle later is accepted.
REQ-030 SHALL cover rst=0 asserted at issue cycle 20 -> all outputs 0 in that cycle, no done; a fresh start then yields a complete correct frame.
REQ-031 SHALL cover back-to-back frames: start on the cycle after done -> the second frame is identical in data and timing to the first.
